// File: rtl/simproc_pkg.sv
// Shared definitions for the simproc_system serial front end.
package simproc_pkg;

  localparam int UART_DATA_BITS   = 8;
  localparam int UART_SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable down-counter that marks the last cycle of a programmed period.
// Loading P makes tick_o fire P cycles later (a period of 0 behaves as 1).
module uart_bit_timer #(
  parameter int CLK_BITS = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_i,
  input  logic [CLK_BITS-1:0] period_i,
  output logic                tick_o
);

  logic [CLK_BITS-1:0] cnt_q, cnt_d;

  // Next count: reload on request, otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = (period_i == '0) ? '0 : period_i - CLK_BITS'(1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CLK_BITS'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/uart_rx_frontend.sv
// 8N1 UART receiver with a one-entry output buffer.
// Output handshake: rx_data is transferred on any clock edge where
// rx_valid=1 and rx_ready=1; rx_data is held stable while rx_valid=1 and
// rx_ready=0, and rx_valid never drops without a transfer.
module uart_rx_frontend
  import simproc_pkg::*;
#(
  parameter int CLK_BITS = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CLK_BITS-1:0] clk_per_bit,
  input  logic                uart_rx,
  output logic [7:0]          rx_data,
  output logic                rx_valid,
  input  logic                rx_ready,
  output logic                frame_err,
  output logic                overrun,
  output logic                busy
);

  logic [UART_SYNC_STAGES-1:0] sync_q;
  logic                        rx_s;
  uart_state_t                 state_q, state_d;
  logic [CLK_BITS-1:0]         n_q, n_d;
  logic [2:0]                  bit_idx_q, bit_idx_d;
  logic [UART_DATA_BITS-1:0]   shift_q, shift_d;
  logic [UART_DATA_BITS-1:0]   data_q, data_d;
  logic                        valid_q, valid_d;
  logic                        ferr_q, ferr_d;
  logic                        ovr_q, ovr_d;
  logic                        timer_load;
  logic [CLK_BITS-1:0]         timer_period;
  logic                        tick;
  logic                        byte_done;

  assign rx_s = sync_q[UART_SYNC_STAGES-1];

  uart_bit_timer #(.CLK_BITS(CLK_BITS)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load_i   (timer_load),
    .period_i (timer_period),
    .tick_o   (tick)
  );

  // Frame FSM: start detection, mid-bit sampling, stop check, break wait.
  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    timer_load   = 1'b0;
    timer_period = n_q;
    byte_done    = 1'b0;
    ferr_d       = 1'b0;
    unique case (state_q)
      IDLE: begin
        // The bit period is captured here so it stays fixed for the frame.
        if (!rx_s && clk_per_bit != '0) begin
          state_d      = START;
          n_d          = clk_per_bit;
          timer_load   = 1'b1;
          timer_period = clk_per_bit >> 1;
        end
      end
      START: begin
        if (tick) begin
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            state_d    = DATA;
            bit_idx_d  = 3'd0;
            timer_load = 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shift_d    = {rx_s, shift_q[UART_DATA_BITS-1:1]};
          timer_load = 1'b1;
          if (bit_idx_q == 3'(UART_DATA_BITS - 1)) state_d = STOP;
          else                                     bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      STOP: begin
        if (tick) begin
          if (rx_s) begin
            byte_done = 1'b1;
            state_d   = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end
      end
      BREAK: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output buffer: load a finished byte unless the old one is still pending.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    if (byte_done) begin
      if (!valid_q || rx_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end
  end

  // All state registers; reset aborts any frame without side effects.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '1;
      state_q   <= IDLE;
      n_q       <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      sync_q    <= {sync_q[UART_SYNC_STAGES-2:0], uart_rx};
      state_q   <= state_d;
      n_q       <= n_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Self-checking bench for uart_rx_frontend: frame table, hand-written corner
// sequences and randomized frames against a transaction-level model.
module tb_uart_rx_frontend;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] clk_per_bit = 10'd16;
  logic       uart_rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  uart_rx_frontend #(.CLK_BITS(10)) dut (
    .clk         (clk),
    .rst         (rst),
    .clk_per_bit (clk_per_bit),
    .uart_rx     (uart_rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .frame_err   (frame_err),
    .overrun     (overrun),
    .busy        (busy)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d required below 90000", cyc);
    $fatal(1);
  end

  // ---------------- bookkeeping ----------------
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // A frame sent at cycle t0 takes effect at t0 + 3 + (N>>1) + 9N:
  // either a byte offered to the buffer or a frame_err pulse.
  typedef struct {
    int         c;
    bit         ferr;
    logic [7:0] b;
  } ev_t;

  ev_t        sched_q[$];
  logic [7:0] exp_q[$];      // expected buffer content (0 or 1 entries)
  bit         m_ferr = 0;
  bit         m_ovr = 0;

  bit         prev_v = 0;
  int         rise_cnt = 0;
  int         rise_cyc = 0;
  logic [7:0] rise_data = 8'h00;
  int         hs_cnt = 0;
  logic [7:0] hs_data = 8'h00;
  int         ferr_cnt = 0;
  int         ovr_cnt = 0;

  ev_t        mev;
  bit         mgot;
  bit         mhs;
  logic [7:0] mb;

  // Monitor: compare outputs with the model each cycle, then advance it.
  always begin
    @(negedge clk);
    #1;
    chk("rx_valid", 32'(rx_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) chk("rx_data", 32'(rx_data), 32'(exp_q[0]));
    chk("frame_err", 32'(frame_err), 32'(m_ferr));
    chk("overrun", 32'(overrun), 32'(m_ovr));

    if (rx_valid && !prev_v) begin
      rise_cnt++;
      rise_cyc  = cyc;
      rise_data = rx_data;
    end
    if (rx_valid && rx_ready) begin
      hs_cnt++;
      hs_data = rx_data;
    end
    if (frame_err) ferr_cnt++;
    if (overrun) ovr_cnt++;
    prev_v = rx_valid;

    mhs    = (exp_q.size() != 0) && rx_ready;
    m_ferr = 0;
    m_ovr  = 0;
    mgot   = 0;
    mb     = 8'h00;
    if (sched_q.size() != 0 && sched_q[0].c == cyc + 1) begin
      mev = sched_q.pop_front();
      if (mev.ferr) m_ferr = 1;
      else begin
        mgot = 1;
        mb   = mev.b;
      end
    end
    if (mgot) begin
      if (exp_q.size() == 0) exp_q.push_back(mb);
      else if (rx_ready) begin
        void'(exp_q.pop_front());
        exp_q.push_back(mb);
      end else m_ovr = 1;
    end else if (mhs) begin
      void'(exp_q.pop_front());
    end
    if (rst) begin
      exp_q.delete();
      sched_q.delete();
      m_ferr = 0;
      m_ovr  = 0;
    end
  end

  // ---------------- drivers ----------------
  bit rand_rdy = 0;
  bit scramble = 0;
  bit scr_now = 0;

  task automatic step();
    @(negedge clk);
    if (rand_rdy) rx_ready = 1'($urandom_range(0, 1));
    if (scr_now) clk_per_bit = 10'($urandom_range(0, 1023));
  endtask

  // Sends one frame at N=n; stop_low>0 drives the stop bit low that long.
  task automatic send_frame(input logic [7:0] b, input int n, input int stop_low,
                            input int lat, output int t0);
    ev_t e;
    step();
    t0 = cyc;
    uart_rx = 1'b0;
    e.c = t0 + lat;
    e.ferr = (stop_low != 0);
    e.b = b;
    sched_q.push_back(e);
    repeat (n - 1) step();
    scr_now = scramble;
    for (int i = 0; i < 8; i++) begin
      step();
      uart_rx = b[i];
      repeat (n - 1) step();
    end
    scr_now = 0;
    clk_per_bit = 10'(n);
    if (stop_low != 0) begin
      step();
      uart_rx = 1'b0;
      repeat (stop_low - 1) step();
      step();
      uart_rx = 1'b1;
    end else begin
      step();
      uart_rx = 1'b1;
      repeat (n - 1) step();
    end
  endtask

  function automatic int lat_of(input int n);
    return 3 + (n / 2) + 9 * n;
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    int         n;
    logic [7:0] b;
    int         stop_low;
    bit         rdy;
    int         exp_lat;
    logic [7:0] exp_data;
    bit         exp_ferr;
  } vec_t;

  vec_t vtab[8];

  initial begin
    int t0, t1, f0, r0, o0, h0, g0, n;
    logic [7:0] b;

    vtab[0] = '{16, 8'h35, 0,  1'b1, 155, 8'h35, 1'b0};
    vtab[1] = '{16, 8'hC3, 0,  1'b1, 155, 8'hC3, 1'b0};
    vtab[2] = '{8,  8'h99, 0,  1'b1, 79,  8'h99, 1'b0};
    vtab[3] = '{4,  8'h5A, 0,  1'b1, 41,  8'h5A, 1'b0};
    vtab[4] = '{12, 8'h00, 0,  1'b1, 117, 8'h00, 1'b0};
    vtab[5] = '{16, 8'hA5, 16, 1'b1, 155, 8'h00, 1'b1};
    vtab[6] = '{9,  8'hFF, 0,  1'b1, 88,  8'hFF, 1'b0};
    vtab[7] = '{2,  8'h81, 0,  1'b1, 22,  8'h81, 1'b0};

    // Reset values.
    rst = 1'b1;
    repeat (3) step();
    chk("rst_rx_data", 32'(rx_data), 32'h00);
    chk("rst_rx_valid", 32'(rx_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_frame_err", 32'(frame_err), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);
    rst = 1'b0;
    repeat (4) step();

    // N=0: receiver disabled while the line toggles.
    clk_per_bit = 10'd0;
    for (int i = 0; i < 100; i++) begin
      step();
      chk("n0_busy", 32'(busy), 32'h0);
      uart_rx = 1'($urandom_range(0, 1));
    end
    uart_rx = 1'b1;
    repeat (4) step();
    chk("n0_no_valid", 32'(rise_cnt), 32'd0);
    clk_per_bit = 10'd8;
    rx_ready = 1'b1;
    send_frame(8'h99, 8, 0, 79, t0);
    repeat (8) step();
    chk("n8_lat", 32'(rise_cyc - t0), 32'd79);
    chk("n8_data", 32'(rise_data), 32'h99);

    // Table of single frames.
    foreach (vtab[i]) begin
      clk_per_bit = 10'(vtab[i].n);
      rx_ready = vtab[i].rdy;
      repeat (4) step();
      r0 = rise_cnt;
      f0 = ferr_cnt;
      send_frame(vtab[i].b, vtab[i].n, vtab[i].stop_low, vtab[i].exp_lat, t0);
      repeat (vtab[i].n + 4) step();
      if (vtab[i].exp_ferr) begin
        chk("tab_ferr_cnt", 32'(ferr_cnt - f0), 32'd1);
        chk("tab_no_rise", 32'(rise_cnt - r0), 32'd0);
      end else begin
        chk("tab_rise_cnt", 32'(rise_cnt - r0), 32'd1);
        chk("tab_lat", 32'(rise_cyc - t0), 32'(vtab[i].exp_lat));
        chk("tab_data", 32'(rise_data), 32'(vtab[i].exp_data));
      end
    end

    // Overrun: two back-to-back frames with the consumer stalled.
    clk_per_bit = 10'd16;
    rx_ready = 1'b0;
    repeat (4) step();
    o0 = ovr_cnt;
    h0 = hs_cnt;
    send_frame(8'h41, 16, 0, 155, t0);
    send_frame(8'h0F, 16, 0, 155, t1);
    chk("ovr_cnt", 32'(ovr_cnt - o0), 32'd1);
    chk("ovr_held_data", 32'(rx_data), 32'h41);
    chk("ovr_held_valid", 32'(rx_valid), 32'h1);
    rx_ready = 1'b1;
    step();
    chk("ovr_hs_data", 32'(hs_data), 32'h41);
    chk("ovr_hs_cnt", 32'(hs_cnt - h0), 32'd1);
    chk("ovr_drained", 32'(rx_valid), 32'h0);
    repeat (8) step();

    // Stop bit held low for 20 cycles, then a clean frame.
    f0 = ferr_cnt;
    r0 = rise_cnt;
    send_frame(8'hA5, 16, 20, 155, t0);
    chk("brk_ferr_cnt", 32'(ferr_cnt - f0), 32'd1);
    chk("brk_busy_low", 32'(busy), 32'h1);
    repeat (2) step();
    chk("brk_busy_hold", 32'(busy), 32'h1);
    repeat (2) step();
    chk("brk_busy_clear", 32'(busy), 32'h0);
    chk("brk_no_rise", 32'(rise_cnt - r0), 32'd0);
    repeat (8) step();
    send_frame(8'h3C, 16, 0, 155, t0);
    repeat (8) step();
    chk("brk_next_lat", 32'(rise_cyc - t0), 32'd155);
    chk("brk_next_data", 32'(rise_data), 32'h3C);

    // Five-cycle glitch rejected by START after H=8 cycles.
    r0 = rise_cnt;
    step();
    g0 = cyc;
    uart_rx = 1'b0;
    repeat (5) step();
    uart_rx = 1'b1;
    chk("gl_busy_start", 32'(busy), 32'h1);
    repeat (5) step();
    chk("gl_busy_last", 32'(busy), 32'h1);
    step();
    chk("gl_busy_idle", 32'(busy), 32'h0);
    chk("gl_cycle", 32'(cyc - g0), 32'd11);
    repeat (40) step();
    chk("gl_no_rise", 32'(rise_cnt - r0), 32'd0);

    // clk_per_bit scrambled during the data bits has no effect.
    scramble = 1;
    send_frame(8'h6E, 16, 0, 155, t0);
    scramble = 0;
    repeat (8) step();
    chk("scr_lat", 32'(rise_cyc - t0), 32'd155);
    chk("scr_data", 32'(rise_data), 32'h6E);

    // Reset mid-DATA with a byte pending in the buffer.
    rx_ready = 1'b0;
    send_frame(8'h55, 16, 0, 155, t0);
    chk("rs_pending", 32'(rx_valid), 32'h1);
    step();
    uart_rx = 1'b0;
    repeat (48) step();
    chk("rs_busy_before", 32'(busy), 32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    uart_rx = 1'b1;
    chk("rs_rx_valid", 32'(rx_valid), 32'h0);
    chk("rs_rx_data", 32'(rx_data), 32'h00);
    chk("rs_busy", 32'(busy), 32'h0);
    chk("rs_frame_err", 32'(frame_err), 32'h0);
    chk("rs_overrun", 32'(overrun), 32'h0);
    repeat (40) step();
    rx_ready = 1'b1;
    send_frame(8'h12, 16, 0, 155, t0);
    repeat (8) step();
    chk("rs_next_lat", 32'(rise_cyc - t0), 32'd155);
    chk("rs_next_data", 32'(rise_data), 32'h12);

    // Randomized frames with a randomly stalling consumer.
    rand_rdy = 1;
    for (int k = 0; k < 14; k++) begin
      n = $urandom_range(2, 24);
      b = 8'($urandom_range(0, 255));
      clk_per_bit = 10'(n);
      repeat (3) step();
      send_frame(b, n, ($urandom_range(0, 5) == 0) ? n : 0, lat_of(n), t0);
      repeat ($urandom_range(0, 2 * n) + 3) step();
    end
    rand_rdy = 0;
    rx_ready = 1'b1;
    repeat (30) step();
    chk("end_sched_empty", 32'(sched_q.size()), 32'd0);
    chk("end_rx_valid", 32'(rx_valid), 32'h0);
    chk("end_busy", 32'(busy), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
